bp_fe_ras_stack: RTL and testbench
==================================

Name: bp_fe_ras_stack

Overview:
- Parametrised multi-entry return address stack for the front-end PC generator; replaces the single-register RAS.
- Calls push their return address; returns predict from, and pop, the top entry.
- Exports a checkpoint (pointer, count) for branch metadata.
- On a backend redirect the checkpoint is restored, optionally repairing the top entry overwritten by a wrong-path push.

Parameters:
vaddr_width_p, 39, virtual address width of stored return addresses
ras_els_p, 8, number of stack entries; power of two, >= 2
ptr_width_lp, $clog2(ras_els_p), derived; stack pointer width
cnt_width_lp, $clog2(ras_els_p+1), derived; occupancy count width

Ports:
clk_i  in  1  clock, all state updates on posedge
reset_n_i  in  1  synchronous active-low reset
push_v_i  in  1  push request (call detected)
push_addr_i  in  vaddr_width_p  return address to push (call PC + 4)
pop_v_i  in  1  pop request (return detected)
top_addr_o  out  vaddr_width_p  predicted return address, entry at pointer
top_v_o  out  1  stack non-empty
pop_underflow_o  out  1  pop-only request while empty (combinational)
ckpt_ptr_o  out  ptr_width_lp  current pointer, for branch metadata
ckpt_cnt_o  out  cnt_width_lp  current count, for branch metadata
restore_v_i  in  1  redirect: restore checkpoint
restore_ptr_i  in  ptr_width_lp  checkpointed pointer
restore_cnt_i  in  cnt_width_lp  checkpointed count
restore_top_v_i  in  1  also rewrite entry at restore_ptr_i
restore_top_addr_i  in  vaddr_width_p  repair value for that entry

Behaviour:
- State: mem[ras_els_p] of vaddr_width_p, ptr_r, cnt_r.
- ptr_r indexes the most recent valid entry.
- Pointer arithmetic is modulo ras_els_p (natural wrap).
- Reset (reset_n_i==0 at posedge): ptr_r=0, cnt_r=0, all mem entries=0.
- Outputs after reset: top_addr_o=0, top_v_o=0, ckpt_ptr_o=0, ckpt_cnt_o=0, pop_underflow_o=pop_v_i&~push_v_i.
- Reset overrides every other input in the same cycle.
- top_addr_o = mem[ptr_r]; top_v_o = (cnt_r!=0). Pure combinational read of registered state, zero latency.
- ckpt_ptr_o/ckpt_cnt_o reflect ptr_r/cnt_r pre-update in the current cycle. This lets the fetch packet record state before its own push/pop.
- Updates take effect next cycle. Priority: reset > restore > push/pop.
- Restore:
  - ptr_r<=restore_ptr_i.
  - cnt_r<=min(restore_cnt_i, ras_els_p).
  - If restore_top_v_i, mem[restore_ptr_i]<=restore_top_addr_i.
  - push_v_i/pop_v_i are ignored that cycle.
- Push only:
  - ptr_r<=ptr_r+1; mem[ptr_r+1]<=push_addr_i.
  - cnt_r<=min(cnt_r+1, ras_els_p).
  - When full, the oldest entry is silently overwritten (circular); cnt_r stays at ras_els_p.
- Pop only:
  - If cnt_r>0: ptr_r<=ptr_r-1, cnt_r<=cnt_r-1, mem unchanged.
  - If cnt_r==0: no state change; pop_underflow_o=1.
- Push and pop same cycle (call that is also ret, e.g. coroutine jalr):
  - If cnt_r>0: mem[ptr_r]<=push_addr_i; ptr_r and cnt_r unchanged.
  - If cnt_r==0: behaves as push only.
  - pop_underflow_o=0.
- Neither request: hold.
- Popped entries are not cleared. A later restore to an older pointer therefore recovers prior contents unless they were overwritten by intervening pushes.
- cnt_r never exceeds ras_els_p and never underflows.

Test Plan:
- Reset then 3 pushes (0x1004, 0x2008, 0x300C) -> top_addr_o=0x300C, cnt=3, ptr=3. Then 3 pops -> tops 0x2008, 0x1004, then top_v_o=0, ptr=0.
- ras_els_p=8: 10 pushes of 0x100·k (k=1..10) -> cnt saturates at 8, ptr=2. Then 8 pops yield 0xA00 down to 0x300; a 9th pop raises pop_underflow_o=1 with no state change.
- Push+pop same cycle with top=0x2008, cnt=2, push_addr=0x4444 -> top=0x4444, cnt=2, ptr unchanged. Same stimulus when empty -> top=0x4444, cnt=1, ptr=1.
- Wrong-path recovery:
  - Record ckpt (ptr=2, cnt=2, top=0x2008).
  - Pop, then push 0x9999; this overwrites entry 2.
  - Restore with ptr=2, cnt=2, restore_top_v_i=1, addr=0x2008 -> top_addr_o=0x2008, cnt=2.
  - A following pop -> top=0x1004.
- Restore with push_v_i=1 and pop_v_i=1 asserted -> push/pop ignored, state equals restored values exactly.
- Assert reset_n_i=0 mid-sequence with cnt=5 and push_v_i=1 -> next cycle cnt=0, ptr=0, top_addr_o=0, top_v_o=0.

Source files
------------

// File: rtl/bp_fe_ras_stack.sv
// bp_fe_ras_stack: circular return address stack for the front-end PC generator.
// Calls push, returns predict from and pop the top entry; a redirect restores a
// (pointer, count) checkpoint and can repair the entry a wrong-path push clobbered.
// Ports:
//   clk_i, reset_n_i           clock, synchronous active-low reset
//   push_v_i, push_addr_i      call: push return address
//   pop_v_i                    return: pop top entry
//   top_addr_o, top_v_o        predicted return address, stack non-empty
//   pop_underflow_o            pop-only request while empty
//   ckpt_ptr_o, ckpt_cnt_o     pre-update pointer/count for branch metadata
//   restore_*                  redirect checkpoint restore and top-entry repair
module bp_fe_ras_stack #(
   parameter int vaddr_width_p = 39,
   parameter int ras_els_p     = 8,
   localparam int ptr_width_lp = $clog2(ras_els_p),
   localparam int cnt_width_lp = $clog2(ras_els_p + 1)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     push_v_i,
   input  logic [vaddr_width_p-1:0] push_addr_i,
   input  logic                     pop_v_i,
   output logic [vaddr_width_p-1:0] top_addr_o,
   output logic                     top_v_o,
   output logic                     pop_underflow_o,
   output logic [ptr_width_lp-1:0]  ckpt_ptr_o,
   output logic [cnt_width_lp-1:0]  ckpt_cnt_o,
   input  logic                     restore_v_i,
   input  logic [ptr_width_lp-1:0]  restore_ptr_i,
   input  logic [cnt_width_lp-1:0]  restore_cnt_i,
   input  logic                     restore_top_v_i,
   input  logic [vaddr_width_p-1:0] restore_top_addr_i
);

   localparam logic [cnt_width_lp-1:0] LP_CNT_MAX = cnt_width_lp'(ras_els_p);

   logic [vaddr_width_p-1:0] r_mem [ras_els_p];
   logic [ptr_width_lp-1:0]  r_ptr;
   logic [cnt_width_lp-1:0]  r_cnt;

   logic                     w_empty;
   logic                     w_full;
   logic [ptr_width_lp-1:0]  w_ptr_inc;
   logic [ptr_width_lp-1:0]  w_ptr_dec;
   logic [cnt_width_lp-1:0]  w_restore_cnt;
   logic                     w_do_push;
   logic                     w_do_swap;
   logic                     w_do_pop;

   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == LP_CNT_MAX);
   assign w_ptr_inc = r_ptr + ptr_width_lp'(1);
   assign w_ptr_dec = r_ptr - ptr_width_lp'(1);

   // The count port is wider than the stack depth, so clamp it.
   assign w_restore_cnt = (restore_cnt_i > LP_CNT_MAX) ? LP_CNT_MAX
                                                       : restore_cnt_i;

   // Push+pop on an empty stack has nothing to replace, so it acts as a push.
   assign w_do_push = push_v_i & (~pop_v_i | w_empty);
   assign w_do_swap = push_v_i & pop_v_i & ~w_empty;
   assign w_do_pop  = pop_v_i & ~push_v_i & ~w_empty;

   assign top_addr_o      = r_mem[r_ptr];
   assign top_v_o         = ~w_empty;
   assign pop_underflow_o = pop_v_i & ~push_v_i & w_empty;
   assign ckpt_ptr_o      = r_ptr;
   assign ckpt_cnt_o      = r_cnt;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_ptr <= '0;
         r_cnt <= '0;
         for (int i = 0; i < ras_els_p; i++) begin
            r_mem[i] <= '0;
         end
      end else if (restore_v_i) begin
         r_ptr <= restore_ptr_i;
         r_cnt <= w_restore_cnt;
         if (restore_top_v_i) begin
            r_mem[restore_ptr_i] <= restore_top_addr_i;
         end
      end else if (w_do_push) begin
         r_ptr          <= w_ptr_inc;
         r_mem[w_ptr_inc] <= push_addr_i;
         // When full the oldest entry is overwritten and the count holds.
         if (!w_full) begin
            r_cnt <= r_cnt + cnt_width_lp'(1);
         end
      end else if (w_do_swap) begin
         r_mem[r_ptr] <= push_addr_i;
      end else if (w_do_pop) begin
         // Popped entries stay in memory so a later restore can recover them.
         r_ptr <= w_ptr_dec;
         r_cnt <= r_cnt - cnt_width_lp'(1);
      end
   end

endmodule

// File: tb/tb_bp_fe_ras_stack.sv
// tb_bp_fe_ras_stack: scoreboard bench for bp_fe_ras_stack.
// Driver queues expected outputs from a reference model; monitor compares.
module tb_bp_fe_ras_stack;

   localparam int W = 39;
   localparam int N = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          push_v;
   logic [W-1:0]  push_addr;
   logic          pop_v;
   logic [W-1:0]  top_addr;
   logic          top_v;
   logic          pop_uf;
   logic [2:0]    ckpt_ptr;
   logic [3:0]    ckpt_cnt;
   logic          rst_v;
   logic [2:0]    rst_ptr;
   logic [3:0]    rst_cnt;
   logic          rst_top_v;
   logic [W-1:0]  rst_top_addr;

   bp_fe_ras_stack #(.vaddr_width_p(W), .ras_els_p(N)) dut (
      .clk_i              (clk),
      .reset_n_i          (reset_n),
      .push_v_i           (push_v),
      .push_addr_i        (push_addr),
      .pop_v_i            (pop_v),
      .top_addr_o         (top_addr),
      .top_v_o            (top_v),
      .pop_underflow_o    (pop_uf),
      .ckpt_ptr_o         (ckpt_ptr),
      .ckpt_cnt_o         (ckpt_cnt),
      .restore_v_i        (rst_v),
      .restore_ptr_i      (rst_ptr),
      .restore_cnt_i      (rst_cnt),
      .restore_top_v_i    (rst_top_v),
      .restore_top_addr_i (rst_top_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        nm;
      logic [W-1:0] top;
      logic         tv;
      logic         uf;
      logic [2:0]   ptr;
      logic [3:0]   cnt;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: plain array, integer pointer and count.
   logic [W-1:0] m_mem [N];
   int           m_ptr;
   int           m_cnt;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         if (top_addr !== e.top || top_v !== e.tv || pop_uf !== e.uf ||
             ckpt_ptr !== e.ptr || ckpt_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL %s: got top=%h v=%b uf=%b ptr=%0d cnt=%0d, want top=%h v=%b uf=%b ptr=%0d cnt=%0d",
                     e.nm, top_addr, top_v, pop_uf, ckpt_ptr, ckpt_cnt,
                     e.top, e.tv, e.uf, e.ptr, e.cnt);
         end
      end
   end

   task automatic step(input string nm, input bit rst, input bit psh,
                       input logic [W-1:0] pa, input bit pp,
                       input bit rv = 1'b0, input int rp = 0, input int rc = 0,
                       input bit rtv = 1'b0, input logic [W-1:0] ra = '0,
                       input bit k = 1'b0, input logic [W-1:0] kt = '0,
                       input int kc = 0, input int kp = 0,
                       input bit chk = 1'b1);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n      = ~rst;
      push_v       = psh;
      push_addr    = pa;
      pop_v        = pp;
      rst_v        = rv;
      rst_ptr      = 3'(rp);
      rst_cnt      = 4'(rc);
      rst_top_v    = rtv;
      rst_top_addr = ra;
      e.nm  = nm;
      e.top = k ? kt : m_mem[m_ptr];
      e.ptr = 3'(k ? kp : m_ptr);
      e.cnt = 4'(k ? kc : m_cnt);
      e.tv  = (k ? kc : m_cnt) != 0;
      e.uf  = pp && !psh && ((k ? kc : m_cnt) == 0);
      if (chk) sb.push_back(e);
      if (rst) begin
         m_ptr = 0;
         m_cnt = 0;
         for (int i = 0; i < N; i++) m_mem[i] = '0;
      end else if (rv) begin
         m_ptr = rp;
         m_cnt = (rc > N) ? N : rc;
         if (rtv) m_mem[rp] = ra;
      end else if (psh && pp && m_cnt > 0) begin
         m_mem[m_ptr] = pa;
      end else if (psh) begin
         m_ptr = (m_ptr + 1) % N;
         m_mem[m_ptr] = pa;
         m_cnt = (m_cnt + 1 > N) ? N : m_cnt + 1;
      end else if (pp && m_cnt > 0) begin
         m_ptr = (m_ptr + N - 1) % N;
         m_cnt = m_cnt - 1;
      end
   endtask

   task automatic do_reset();
      step("reset", 1'b1, 1'b0, '0, 1'b0);
   endtask

   task automatic push(input logic [W-1:0] a);
      step("push", 1'b0, 1'b1, a, 1'b0);
   endtask

   task automatic pop();
      step("pop", 1'b0, 1'b0, '0, 1'b0 | 1'b1);
   endtask

   task automatic expect_k(input string nm, input logic [W-1:0] t,
                           input int c, input int p);
      step(nm, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b1, t, c, p);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] r64;
      int          op;
      reset_n = 1'b0; push_v = 1'b0; push_addr = '0; pop_v = 1'b0;
      rst_v = 1'b0; rst_ptr = '0; rst_cnt = '0; rst_top_v = 1'b0;
      rst_top_addr = '0;
      for (int i = 0; i < N; i++) m_mem[i] = '0;
      m_ptr = 0; m_cnt = 0;
      step("reset0", 1'b1, 1'b0, '0, 1'b0, .chk(1'b0));
      do_reset();
      expect_k("reset_state", '0, 0, 0);

      push(39'h1004); push(39'h2008); push(39'h300C);
      expect_k("push3", 39'h300C, 3, 3);
      pop(); pop(); pop();
      expect_k("pop3", '0, 0, 0);

      do_reset();
      for (int k = 1; k <= 10; k++) push(39'(k * 'h100));
      expect_k("sat", 39'hA00, 8, 2);
      for (int i = 0; i < 8; i++)
         step("drain", 1'b0, 1'b0, '0, 1'b1, 1'b0, 0, 0, 1'b0, '0,
              1'b1, 39'((10 - i) * 'h100), 8 - i, (2 - i + N) % N);
      step("underflow", 1'b0, 1'b0, '0, 1'b1, 1'b0, 0, 0, 1'b0, '0,
           1'b1, 39'hA00, 0, 2);
      expect_k("uf_hold", 39'hA00, 0, 2);

      do_reset();
      push(39'h1004); push(39'h2008);
      step("swap", 1'b0, 1'b1, 39'h4444, 1'b1);
      expect_k("swap_res", 39'h4444, 2, 2);
      do_reset();
      step("swap_empty", 1'b0, 1'b1, 39'h4444, 1'b1);
      expect_k("swap_empty_res", 39'h4444, 1, 1);

      do_reset();
      push(39'h1004); push(39'h2008);
      expect_k("ckpt", 39'h2008, 2, 2);
      pop();
      push(39'h9999);
      expect_k("wrong_path", 39'h9999, 2, 2);
      step("restore", 1'b0, 1'b1, 39'h5555, 1'b1, 1'b1, 2, 2, 1'b1, 39'h2008);
      expect_k("restored", 39'h2008, 2, 2);
      pop();
      expect_k("after_restore_pop", 39'h1004, 1, 1);
      step("restore_clamp", 1'b0, 1'b0, '0, 1'b0, 1'b1, 5, 15);
      expect_k("clamped", '0, 8, 5);

      do_reset();
      for (int i = 0; i < 5; i++) push(39'(i + 1));
      step("mid_reset", 1'b1, 1'b1, 39'h7777, 1'b0);
      expect_k("mid_reset_res", '0, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         r64 = {$urandom(), $urandom()};
         op = $urandom_range(0, 99);
         if (op < 2) begin
            do_reset();
         end else if (op < 10) begin
            step("rnd_restore", 1'b0, 1'($urandom_range(0, 1)), r64[W-1:0],
                 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 7),
                 $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                 39'(r64[63:25]));
         end else begin
            step("rnd", 1'b0, 1'($urandom_range(0, 1)), r64[W-1:0],
                 1'($urandom_range(0, 1)));
         end
      end

      @(negedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
